// File: rtl/otter_pkg.sv
// Shared OTTER definitions: PC source select encoding and the default fetch reset vector.
package otter_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_TRAP   = 3'd4,
    PC_MRET   = 3'd5
  } pc_src_t;

  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;

  // Instruction fetch is always word aligned, whatever the target generator produced.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_fetch_fifo.sv
// Small circular FIFO with synchronous flush; holds either fetched
// {instr, pc} pairs or the PCs of requests still awaiting a response.
module otter_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
    if (ptr == LAST) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  // Storage write; flush only rewinds the pointers so the data needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; the owner never pushes when full or pops when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= push ? bump(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop ? bump(rd_ptr_r) : rd_ptr_r;
      count_r  <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/otter_fetch_unit_chk.sv
// Protocol checker for the fetch memory port: tracks grants against responses
// from the ports alone and flags responses that arrive with nothing in flight.
module otter_fetch_unit_chk #(
  parameter int BUF_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic req,
  input logic gnt,
  input logic rvalid
);

  int outstanding_r;

  // Independent in-flight count, same ignore-on-empty rule as the fetch unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= 0;
    end else begin
      outstanding_r <= outstanding_r + int'(req && gnt) - int'(rvalid && (outstanding_r != 0));
    end
  end

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (outstanding_r != 0));

  a_outstanding_bounded: assert property (@(posedge clk) disable iff (rst)
    outstanding_r <= BUF_DEPTH);

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch front end: owns the fetch PC, issues word fetches,
// buffers responses for decode and drops in-flight fetches after a redirect.
module otter_fetch_unit
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = OTTER_RESET_VEC,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT_VALID,
  input  logic [2:0]  PC_SRC,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  input  logic        IF_READY
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] drop_cnt_r;
  logic          redirect_s;
  logic [31:0]   target_s;
  logic          grant_s;
  logic          rsp_s;
  logic          keep_s;
  logic          consume_s;
  logic [CW-1:0] pend_count_s;
  logic [CW-1:0] buf_count_s;
  logic [31:0]   pend_head_s;
  logic [63:0]   buf_head_s;

  // Redirect decode; the unused encodings behave as sequential fetch.
  always_comb begin
    redirect_s = 1'b0;
    target_s   = fetch_pc_r;
    case (PC_SRC)
      PC_JALR:   begin redirect_s = REDIRECT_VALID; target_s = JALR;   end
      PC_BRANCH: begin redirect_s = REDIRECT_VALID; target_s = BRANCH; end
      PC_JAL:    begin redirect_s = REDIRECT_VALID; target_s = JAL;    end
      PC_TRAP:   begin redirect_s = REDIRECT_VALID; target_s = MTVEC;  end
      PC_MRET:   begin redirect_s = REDIRECT_VALID; target_s = MEPC;   end
      default:   begin redirect_s = 1'b0;           target_s = fetch_pc_r; end
    endcase
  end

  // In-flight plus buffered fetches never exceed the buffer, so a push can never overflow it.
  assign IMEM_REQ  = !RST && !redirect_s && (drop_cnt_r == {CW{1'b0}}) &&
                     (({1'b0, pend_count_s} + {1'b0, buf_count_s}) < DEPTH_V);
  assign IMEM_ADDR = fetch_pc_r;
  assign grant_s   = IMEM_REQ && IMEM_GNT;
  assign rsp_s     = IMEM_RVALID && (pend_count_s != {CW{1'b0}});
  assign keep_s    = rsp_s && !redirect_s && (drop_cnt_r == {CW{1'b0}});
  assign consume_s = IF_VALID && IF_READY;

  // Fetch PC and stale-response bookkeeping; a redirect never coincides with a grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc_r <= RESET_VEC;
      drop_cnt_r <= {CW{1'b0}};
    end else begin
      if (redirect_s) begin
        fetch_pc_r <= word_align(target_s);
      end else if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (redirect_s) begin
        drop_cnt_r <= pend_count_s - CW'(rsp_s);
      end else if (rsp_s && (drop_cnt_r != {CW{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  otter_fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pending (
    .clk       (CLK),
    .rst       (RST),
    .flush     (1'b0),
    .push      (grant_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_s),
    .head      (pend_head_s),
    .count     (pend_count_s)
  );

  otter_fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_ibuf (
    .clk       (CLK),
    .rst       (RST),
    .flush     (redirect_s),
    .push      (keep_s),
    .push_data ({IMEM_RDATA, pend_head_s}),
    .pop       (consume_s),
    .head      (buf_head_s),
    .count     (buf_count_s)
  );

  assign IF_VALID = (buf_count_s != {CW{1'b0}});
  assign IF_INSTR = IF_VALID ? buf_head_s[63:32] : 32'h0000_0000;
  assign IF_PC    = IF_VALID ? buf_head_s[31:0]  : 32'h0000_0000;

endmodule
